// File: rtl/shadow_reg_bank.sv
// Double-buffered register bank: a writable working array and a shadow array
// that only changes on commit, copied atomically or one entry per cycle.
module shadow_reg_bank #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 4,
  parameter int              COPY_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              CNT_W     = 8,
  localparam int             ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              clr,
  input  logic              commit_req,
  output logic              busy,
  output logic              commit_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic [CNT_W-1:0]  commit_cnt
);

  localparam logic [ADDR_W:0]   DEPTH_E  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, COPY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              commit_go;
  logic              commit_done;
  logic              wr_in_range;
  logic              rd_in_range;

  logic [WIDTH-1:0] working [DEPTH];
  logic [WIDTH-1:0] shadow  [DEPTH];

  assign commit_go   = commit_req && (state == IDLE);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_E);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_E);
  assign busy        = (state == COPY);
  assign wr_ready    = (state == IDLE);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    commit_done = 1'b0;
    if (COPY_MODE == 0) begin
      commit_done = commit_go;
    end else begin
      case (state)
        IDLE: begin
          if (commit_go) begin
            state_nxt = COPY;
            idx_nxt   = '0;
          end
        end
        COPY: begin
          idx_nxt = idx + ADDR_W'(1);
          if (idx == LAST_IDX) begin
            state_nxt   = IDLE;
            commit_done = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes commit see working as it
  // stood before a same-cycle write, and a read see the old shadow entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // NOTE: both arrays sit in the async reset because every entry must read
  // back as RESET_VAL after reset, so they build as flops rather than RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) working[i] <= RESET_VAL;
    end else if (wr_ready) begin
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) working[i] <= RESET_VAL;
      end else if (wr_en && wr_in_range) begin
        working[wr_addr] <= wr_data;
      end
    end
  end

  // Working is frozen while copying, so the serial snapshot stays consistent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= RESET_VAL;
    end else if (COPY_MODE == 0) begin
      if (commit_go) begin
        for (int i = 0; i < DEPTH; i++) shadow[i] <= working[i];
      end
    end else if (state == COPY) begin
      shadow[idx] <= working[idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_ack <= 1'b0;
      commit_cnt <= '0;
      rd_data    <= RESET_VAL;
    end else begin
      commit_ack <= commit_done;
      if (commit_done) commit_cnt <= commit_cnt + CNT_W'(1);
      rd_data <= rd_in_range ? shadow[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_shadow_reg_bank.sv
// Scoreboard bench for shadow_reg_bank: three configurations share one stimulus
// stream and are checked against an array-level model of the bank.
module tb_shadow_reg_bank;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, clr, commit_req;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic       req [N];

  logic [7:0] rd0, rd1, rd2;
  logic       busy0, busy1, busy2;
  logic       rdy0, rdy1, rdy2;
  logic       ack0, ack1, ack2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  logic [7:0] obs_rd   [N];
  logic       obs_busy [N];
  logic       obs_rdy  [N];
  logic       obs_ack  [N];
  logic [7:0] obs_cnt  [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // The serial instance never sees a commit in the same cycle as a write/clr.
  always_comb begin
    req[0] = commit_req;
    req[1] = commit_req & ~wr_en & ~clr;
    req[2] = commit_req;
  end

  shadow_reg_bank #(.WIDTH(8), .DEPTH(4), .COPY_MODE(0), .RESET_VAL(8'h00), .CNT_W(8)) u_atom (
    .clk(clk), .reset_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
    .wr_ready(rdy0), .clr(clr), .commit_req(req[0]), .busy(busy0), .commit_ack(ack0),
    .rd_addr(rd_addr[1:0]), .rd_data(rd0), .commit_cnt(cnt0));

  shadow_reg_bank #(.WIDTH(8), .DEPTH(4), .COPY_MODE(1), .RESET_VAL(8'h00), .CNT_W(8)) u_serial (
    .clk(clk), .reset_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
    .wr_ready(rdy1), .clr(clr), .commit_req(req[1]), .busy(busy1), .commit_ack(ack1),
    .rd_addr(rd_addr[1:0]), .rd_data(rd1), .commit_cnt(cnt1));

  shadow_reg_bank #(.WIDTH(8), .DEPTH(5), .COPY_MODE(0), .RESET_VAL(8'h5A), .CNT_W(2)) u_odd (
    .clk(clk), .reset_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(rdy2), .clr(clr), .commit_req(req[2]), .busy(busy2), .commit_ack(ack2),
    .rd_addr(rd_addr), .rd_data(rd2), .commit_cnt(cnt2));

  always_comb begin
    obs_rd[0] = rd0;   obs_rd[1] = rd1;   obs_rd[2] = rd2;
    obs_busy[0] = busy0; obs_busy[1] = busy1; obs_busy[2] = busy2;
    obs_rdy[0] = rdy0; obs_rdy[1] = rdy1; obs_rdy[2] = rdy2;
    obs_ack[0] = ack0; obs_ack[1] = ack1; obs_ack[2] = ack2;
    obs_cnt[0] = cnt0; obs_cnt[1] = cnt1; obs_cnt[2] = {6'b0, cnt2};
  end

  // Per-instance configuration as seen by the model.
  function automatic int dep(input int d);  return (d == 2) ? 5 : 4;       endfunction
  function automatic int mode(input int d); return (d == 1) ? 1 : 0;       endfunction
  function automatic int cntw(input int d); return (d == 2) ? 2 : 8;       endfunction
  function automatic int aw(input int d);   return (d == 2) ? 3 : 2;       endfunction
  function automatic int rv(input int d);   return (d == 2) ? 8'h5A : 0;   endfunction

  typedef struct {
    int d;
    int rd;
    int busy;
    int rdy;
    int cnt;
  } exp_t;

  exp_t sb [$];
  int   ackq [N][$];

  int mw [N][8];
  int ms [N][8];
  int copy_left [N];
  int copy_pos  [N];
  int mcnt      [N];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one bank for one clock edge, using the inputs sampled at that edge.
  task automatic model_step(input int d);
    int   mask, wa, ra, rd_exp;
    bit   ready, done;
    int   old_w [8];
    exp_t e;
    mask = (1 << aw(d)) - 1;
    wa   = int'(wr_addr) & mask;
    ra   = int'(rd_addr) & mask;
    e.d  = d;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mw[d][i] = rv(d);
        ms[d][i] = rv(d);
      end
      copy_left[d] = 0;
      copy_pos[d]  = 0;
      mcnt[d]      = 0;
      e.rd = rv(d); e.busy = 0; e.rdy = 1; e.cnt = 0;
      sb.push_back(e);
      return;
    end
    rd_exp = (ra < dep(d)) ? ms[d][ra] : 0;
    ready  = (copy_left[d] == 0);
    done   = 1'b0;
    for (int i = 0; i < 8; i++) old_w[i] = mw[d][i];
    if (mode(d) == 0) begin
      if (req[d]) begin
        for (int i = 0; i < dep(d); i++) ms[d][i] = old_w[i];
        done = 1'b1;
      end
    end else if (copy_left[d] > 0) begin
      ms[d][copy_pos[d]] = old_w[copy_pos[d]];
      copy_pos[d]++;
      copy_left[d]--;
      done = (copy_left[d] == 0);
    end else if (req[d]) begin
      copy_left[d] = dep(d);
      copy_pos[d]  = 0;
    end
    if (ready) begin
      if (clr) begin
        for (int i = 0; i < dep(d); i++) mw[d][i] = rv(d);
      end else if (wr_en && wa < dep(d)) begin
        mw[d][wa] = int'(wr_data);
      end
    end
    if (done) begin
      mcnt[d] = (mcnt[d] + 1) % (1 << cntw(d));
      ackq[d].push_back(mcnt[d]);
    end
    e.rd   = rd_exp;
    e.busy = (copy_left[d] > 0) ? 1 : 0;
    e.rdy  = (copy_left[d] > 0) ? 0 : 1;
    e.cnt  = mcnt[d];
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int d = 0; d < N; d++) model_step(d);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; clr = 1'b0; commit_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  // Monitor: compares everything expected from the previous edge.
  always @(negedge clk) begin
    exp_t e;
    int   c;
    bit   exp_ack;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("rd_data[%0d]", e.d), int'(obs_rd[e.d]), e.rd);
      check($sformatf("busy[%0d]", e.d), int'(obs_busy[e.d]), e.busy);
      check($sformatf("wr_ready[%0d]", e.d), int'(obs_rdy[e.d]), e.rdy);
      check($sformatf("commit_cnt[%0d]", e.d), int'(obs_cnt[e.d]), e.cnt);
    end
    for (int d = 0; d < N; d++) begin
      exp_ack = (ackq[d].size() > 0);
      check($sformatf("commit_ack[%0d]", d), int'(obs_ack[d]), int'(exp_ack));
      if (exp_ack) begin
        c = ackq[d].pop_front();
        if (obs_ack[d]) check($sformatf("ack_cnt[%0d]", d), int'(obs_cnt[d]), c);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #1 rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;

    // Reset state readback.
    for (int a = 0; a < 4; a++) begin rd_addr = 3'(a); cyc(); end

    // Load 10..40, read before commit, commit, read back.
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 8'((a + 1) * 10); cyc();
    end
    wr_en = 1'b0; rd_addr = 3'd2; cyc();
    commit_req = 1'b1; cyc(); commit_req = 1'b0;
    for (int a = 0; a < 4; a++) begin rd_addr = 3'(a); cyc(); end
    repeat (4) cyc();

    // Same-cycle write during an atomic commit lands in working only.
    commit_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'd99; cyc();
    commit_req = 1'b0; wr_en = 1'b0; rd_addr = 3'd1; cyc(); cyc();
    commit_req = 1'b1; cyc(); commit_req = 1'b0;
    repeat (6) cyc();

    // Serial commit; write and commit during busy are dropped.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'd10; cyc(); wr_en = 1'b0;
    commit_req = 1'b1; cyc(); commit_req = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'd77; cyc(); wr_en = 1'b0;
    commit_req = 1'b1; cyc(); commit_req = 1'b0;
    for (int a = 0; a < 6; a++) begin rd_addr = 3'(a % 4); cyc(); end

    // Reset in the middle of a serial copy.
    commit_req = 1'b1; cyc(); commit_req = 1'b0;
    cyc(); cyc();
    @(negedge clk); #1 rst_n = 1'b0; #1;
    check("async_busy1", int'(busy1), 0);
    check("async_rdy1", int'(rdy1), 1);
    check("async_cnt1", int'(cnt1), 0);
    check("async_cnt0", int'(cnt0), 0);
    check("async_rd1", int'(rd1), 0);
    check("async_rd2", int'(rd2), 8'h5A);
    cyc(); cyc();
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin rd_addr = 3'(a); cyc(); end
    commit_req = 1'b1; cyc(); commit_req = 1'b0;
    for (int a = 0; a < 6; a++) begin rd_addr = 3'(a % 4); cyc(); end

    // Boundaries: out-of-range write/read, clr beating wr_en, counter wrap.
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hEE; cyc();
    wr_en = 1'b0; rd_addr = 3'd6; cyc();
    clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h33; cyc();
    clr = 1'b0; wr_en = 1'b0;
    commit_req = 1'b1; repeat (4) cyc(); commit_req = 1'b0;
    repeat (5) cyc();
    for (int a = 0; a < 8; a++) begin rd_addr = 3'(a); cyc(); end

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = 3'($urandom_range(0, 7));
      wr_data    = 8'($urandom);
      clr        = ($urandom_range(0, 15) == 0);
      commit_req = ($urandom_range(0, 5) == 0);
      rd_addr    = 3'($urandom_range(0, 7));
      cyc();
    end
    idle_inputs();
    repeat (8) cyc();
    @(negedge clk); #1;
    for (int d = 0; d < N; d++) check($sformatf("ack_drain[%0d]", d), ackq[d].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
